aes_job_launcher: RTL
=====================

# aes_job_launcher

Peripheral-bus initiator that drives the configuration port of the AES HWPE from the master side. It accepts a job descriptor (N_JOB_REGS 32-bit words) over a valid/ready handshake and acquires a job slot by reading ACQUIRE, retrying while busy. It then writes the descriptor into the generic job registers, writes TRIGGER, and waits for completion before reporting done with the job ID. It sits between a local sequencer (test harness or DMA front-end) and the AES HWPE control slave.

## Interface
- N_JOB_REGS, 8, descriptor words written per job (1..16)
- BASE_ADDR, 32'h0000_0000, HWPE register base address
- ID_WIDTH, 10, width of periph request/response ID
- MASTER_ID, 0, ID driven on every request
- RETRY_GAP, 8, idle cycles between ACQUIRE retries (≥1)
- POLL_GAP, 16, idle cycles between STATUS polls (≥1)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- job_valid_i  in  1  descriptor valid
- job_ready_o  out  1  launcher idle, accepts descriptor
- job_regs_i  in  N_JOB_REGS×32  descriptor words; sampled on accept
- done_o  out  1  one-cycle pulse, job completed
- done_id_o  out  8  job ID of completed job, held until next done
- busy_o  out  1  high from accept through done pulse
- periph_req_o  out  1  request
- periph_gnt_i  in  1  grant
- periph_add_o  out  32  byte address
- periph_wen_o  out  1  0 = write, 1 = read
- periph_be_o  out  4  byte enables, always 4'hF
- periph_data_o  out  32  write data
- periph_id_o  out  ID_WIDTH  request ID (MASTER_ID)
- periph_r_data_i  in  32  read data
- periph_r_valid_i  in  1  read response valid
- periph_r_id_i  in  ID_WIDTH  response ID
- evt_i  in  1  HWPE end-of-job event (used when polling is compiled out)

## Operation
- Register offsets from BASE_ADDR: TRIGGER 0x00, ACQUIRE 0x04, STATUS 0x0C, job regs 0x40 + 4·k.
- States: IDLE, ACQ, ACQ_RSP, BACKOFF, WR, TRIG, WAIT, POLL, POLL_RSP, GAP, DONE.
- IDLE: job_ready_o=1; on job_valid_i, latch the descriptor and go to ACQ.
- ACQ: read ACQUIRE. ACQ_RSP: on response, if r_data[31] is set (slot busy), go to BACKOFF; else latch r_data[7:0] as the job ID and go to WR with k=0.
- BACKOFF: count RETRY_GAP cycles, then return to ACQ.
- WR: write word k to 0x40+4k, with k counting 0..N_JOB_REGS-1; after the last grant, go to TRIG.
- TRIG: write 0 to TRIGGER; after grant, go to WAIT (event mode) or GAP (poll mode).
- WAIT: on evt_i, go to DONE.
- POLL: read STATUS. POLL_RSP: if r_data==0, go to DONE; else go to GAP. GAP: count POLL_GAP cycles, then go to POLL.
- DONE: pulse done_o, update done_id_o, return to IDLE.
- Read responses with r_id≠MASTER_ID, or arriving outside *_RSP states, are ignored.

## Timing
- Reset values: job_ready_o=0 during reset then 1; done_o=0, done_id_o=0, busy_o=0, periph_req_o=0, add/data/wen/id/be = 0/0/1/MASTER_ID/F.
- Reset mid-transaction: req drops on the next edge; the FSM returns to IDLE and any pending response is ignored.
- Requests are registered. req rises the cycle after the state is entered. add/wen/data stay stable while req=1 and gnt=0. The request completes on the edge where req&gnt=1.
- Back-to-back writes: the next beat's req is asserted in the cycle after a grant, so there is one req-high cycle per beat when gnt is always 1.
- r_valid may arrive no earlier than the cycle after the grant. A response arriving in the same cycle as a grant is not that grant's response.
- evt_i asserted while not in WAIT is ignored and not latched.
- Latency with gnt tied high, r_valid one cycle after gnt, and slot free: accept→TRIGGER grant = 3 + N_JOB_REGS + 1 cycles.
- done_o is asserted one cycle after the completion condition.

## Configuration
- AES_LAUNCHER_POLL_EN defined: completion is detected by STATUS polling (POLL/POLL_RSP/GAP); evt_i is unused.
- AES_LAUNCHER_POLL_EN undefined: completion is detected by evt_i in WAIT; no STATUS reads are issued and the poll states and POLL_GAP counter are absent.

## Structure
- aes_package holds the offset constants (AES_REG_TRIGGER, AES_REG_ACQUIRE, AES_REG_STATUS, AES_REG_JOB_BASE) and the launcher state enum type.
- One sub-module, aes_periph_txn: a single-transaction engine covering req/gnt hold, read-response capture with ID filtering, and a done strobe. The FSM drives it with addr/wen/data/start.

## Test plan
- gnt tied 1, ACQUIRE returns 0x0000_0003, N_JOB_REGS=8 with words 0xA0..0xA7 -> writes to 0x40..0x5C in order, TRIGGER write of 0, done_id_o=3 after evt_i.
- gnt delayed 3 cycles per request -> add/data stable throughout each stall; no beat is duplicated or skipped.
- ACQUIRE returns 0xFFFF_FFFF twice, then 0x1 -> three ACQUIRE reads spaced ≥RETRY_GAP idle cycles apart; job ID 1.
- AES_LAUNCHER_POLL_EN defined, STATUS returns 1, 1, 0 -> three polls spaced by POLL_GAP; a single done_o pulse.
- Response with r_id=MASTER_ID+1 during ACQ_RSP -> ignored; the following matching response is used.
- rst_i asserted during the 4th write beat -> req=0 on the next edge, outputs at reset values; a new job completes normally afterward.

Source files
------------

// File: rtl/aes_job_launcher_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_package
// Purpose  : AES HWPE register offsets and the launcher state type.
//            State set depends on AES_LAUNCHER_POLL_EN.
// Revision : 1.0
// ============================================================================
package aes_package;

    localparam logic [31:0] AES_REG_TRIGGER  = 32'h0000_0000;
    localparam logic [31:0] AES_REG_ACQUIRE  = 32'h0000_0004;
    localparam logic [31:0] AES_REG_STATUS   = 32'h0000_000C;
    localparam logic [31:0] AES_REG_JOB_BASE = 32'h0000_0040;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ACQ      = 4'd1,
        ST_ACQ_RSP  = 4'd2,
        ST_BACKOFF  = 4'd3,
        ST_WR       = 4'd4,
        ST_TRIG     = 4'd5,
`ifdef AES_LAUNCHER_POLL_EN
        ST_POLL     = 4'd7,
        ST_POLL_RSP = 4'd8,
        ST_GAP      = 4'd9,
`else
        ST_WAIT     = 4'd6,
`endif
        ST_DONE     = 4'd10
    } launcher_state_t;

    function automatic logic [31:0] job_reg_addr(input logic [31:0] base,
                                                 input logic [4:0]  idx);
        return base + AES_REG_JOB_BASE + {25'd0, idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_job_launcher_periph_txn.sv
`default_nettype none
// ============================================================================
// Module   : aes_periph_txn
// Purpose  : Single peripheral-bus transaction engine: registered request held
//            until grant, read-response capture filtered by ID.
// Revision : 1.0
// ============================================================================
module aes_periph_txn #(
    parameter int ID_WIDTH  = 10,
    parameter int MASTER_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [31:0]         i_addr,
    input  logic                i_wen,
    input  logic [31:0]         i_data,
    output logic                o_gnt_done,
    output logic                o_rsp_valid,
    output logic [31:0]         o_rsp_data,
    output logic                o_periph_req,
    input  logic                i_periph_gnt,
    output logic [31:0]         o_periph_add,
    output logic                o_periph_wen,
    output logic [3:0]          o_periph_be,
    output logic [31:0]         o_periph_data,
    output logic [ID_WIDTH-1:0] o_periph_id,
    input  logic [31:0]         i_periph_r_data,
    input  logic                i_periph_r_valid,
    input  logic [ID_WIDTH-1:0] i_periph_r_id
);

    localparam logic [ID_WIDTH-1:0] c_master_id = ID_WIDTH'(MASTER_ID);

    logic        r_req;
    logic        r_wen;
    logic        r_rsp_pend;
    logic [31:0] r_add;
    logic [31:0] r_data;

    // The pending flag is set on the grant edge, so a response coincident
    // with the grant is never mistaken for that grant's response.
    assign o_gnt_done  = r_req & i_periph_gnt;
    assign o_rsp_valid = r_rsp_pend & i_periph_r_valid & (i_periph_r_id == c_master_id);
    assign o_rsp_data  = i_periph_r_data;

    assign o_periph_req  = r_req;
    assign o_periph_add  = r_add;
    assign o_periph_wen  = r_wen;
    assign o_periph_data = r_data;
    assign o_periph_be   = 4'hF;
    assign o_periph_id   = c_master_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req      <= 1'b0;
            r_wen      <= 1'b1;
            r_add      <= 32'd0;
            r_data     <= 32'd0;
            r_rsp_pend <= 1'b0;
        end else begin
            if (i_start) begin
                r_req  <= 1'b1;
                r_add  <= i_addr;
                r_wen  <= i_wen;
                r_data <= i_data;
            end else if (o_gnt_done) begin
                r_req <= 1'b0;
            end

            if (o_gnt_done && r_wen) begin
                r_rsp_pend <= 1'b1;
            end else if (o_rsp_valid) begin
                r_rsp_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_job_launcher.sv
`default_nettype none
// ============================================================================
// Module   : aes_job_launcher
// Purpose  : Acquires an AES HWPE job slot, writes the descriptor, triggers and
//            waits for completion. AES_LAUNCHER_POLL_EN selects STATUS polling.
// Revision : 1.0
// ============================================================================
module aes_job_launcher
    import aes_package::*;
#(
    parameter int          N_JOB_REGS = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ID_WIDTH   = 10,
    parameter int          MASTER_ID  = 0,
    parameter int          RETRY_GAP  = 8,
    parameter int          POLL_GAP   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [N_JOB_REGS*32-1:0] job_regs_i,
    output logic                    done_o,
    output logic [7:0]              done_id_o,
    output logic                    busy_o,
    output logic                    periph_req_o,
    input  logic                    periph_gnt_i,
    output logic [31:0]             periph_add_o,
    output logic                    periph_wen_o,
    output logic [3:0]              periph_be_o,
    output logic [31:0]             periph_data_o,
    output logic [ID_WIDTH-1:0]     periph_id_o,
    input  logic [31:0]             periph_r_data_i,
    input  logic                    periph_r_valid_i,
    input  logic [ID_WIDTH-1:0]     periph_r_id_i,
    input  logic                    evt_i
);

    localparam int CNT_W  = 16;
    localparam int BEAT_W = 5;

    localparam logic [CNT_W-1:0]  c_retry_last = CNT_W'(RETRY_GAP - 1);
    localparam logic [BEAT_W-1:0] c_last_beat  = BEAT_W'(N_JOB_REGS - 1);

    launcher_state_t          r_state;
    logic [N_JOB_REGS*32-1:0] r_regs;
    logic [7:0]               r_job_id;
    logic [BEAT_W-1:0]        r_beat;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_job_ready;
    logic                     r_busy;
    logic                     r_done;
    logic [7:0]               r_done_id;

    logic                     w_start;
    logic [31:0]              w_addr;
    logic                     w_wen;
    logic [31:0]              w_data;
    logic                     w_gnt_done;
    logic                     w_rsp_valid;
    logic [31:0]              w_rsp_data;
    logic [BEAT_W-1:0]        w_next_beat;

    assign w_next_beat = r_beat + 5'd1;

    assign job_ready_o = r_job_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign done_id_o   = r_done_id;

`ifdef AES_LAUNCHER_POLL_EN
    localparam logic [CNT_W-1:0] c_poll_last = CNT_W'(POLL_GAP - 1);
    logic w_unused;
    assign w_unused = evt_i;
`else
    logic w_unused;
    assign w_unused = ^w_rsp_data[30:8];
`endif

    // Next request is launched in the cycle its predecessor completes, so
    // the bus sees one req-high cycle per beat under a tied-high grant.
    always_comb begin
        w_start = 1'b0;
        w_addr  = BASE_ADDR + AES_REG_ACQUIRE;
        w_wen   = 1'b1;
        w_data  = 32'd0;
        case (r_state)
            ST_ACQ: begin
                w_start = 1'b1;
            end
            ST_ACQ_RSP: begin
                if (w_rsp_valid && !w_rsp_data[31]) begin
                    w_start = 1'b1;
                    w_wen   = 1'b0;
                    w_addr  = job_reg_addr(BASE_ADDR, 5'd0);
                    w_data  = r_regs[31:0];
                end
            end
            ST_WR: begin
                if (w_gnt_done) begin
                    w_start = 1'b1;
                    w_wen   = 1'b0;
                    if (r_beat == c_last_beat) begin
                        w_addr = BASE_ADDR + AES_REG_TRIGGER;
                        w_data = 32'd0;
                    end else begin
                        w_addr = job_reg_addr(BASE_ADDR, w_next_beat);
                        w_data = r_regs[w_next_beat*32 +: 32];
                    end
                end
            end
`ifdef AES_LAUNCHER_POLL_EN
            ST_POLL: begin
                w_start = 1'b1;
                w_addr  = BASE_ADDR + AES_REG_STATUS;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_regs      <= '0;
            r_job_id    <= 8'd0;
            r_beat      <= '0;
            r_cnt       <= '0;
            r_job_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_job_ready <= 1'b1;
                    if (job_valid_i && r_job_ready) begin
                        r_regs      <= job_regs_i;
                        r_job_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    r_state <= ST_ACQ_RSP;
                end
                ST_ACQ_RSP: begin
                    if (w_rsp_valid) begin
                        if (w_rsp_data[31]) begin
                            r_cnt   <= '0;
                            r_state <= ST_BACKOFF;
                        end else begin
                            r_job_id <= w_rsp_data[7:0];
                            r_beat   <= '0;
                            r_state  <= ST_WR;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (r_cnt == c_retry_last) begin
                        r_state <= ST_ACQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    if (w_gnt_done) begin
                        if (r_beat == c_last_beat) begin
                            r_state <= ST_TRIG;
                        end else begin
                            r_beat <= w_next_beat;
                        end
                    end
                end
                ST_TRIG: begin
                    if (w_gnt_done) begin
`ifdef AES_LAUNCHER_POLL_EN
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
`else
                        r_state <= ST_WAIT;
`endif
                    end
                end
`ifdef AES_LAUNCHER_POLL_EN
                ST_POLL: begin
                    r_state <= ST_POLL_RSP;
                end
                ST_POLL_RSP: begin
                    if (w_rsp_valid) begin
                        if (w_rsp_data == 32'd0) begin
                            r_done    <= 1'b1;
                            r_done_id <= r_job_id;
                            r_state   <= ST_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_poll_last) begin
                        r_state <= ST_POLL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`else
                ST_WAIT: begin
                    if (evt_i) begin
                        r_done    <= 1'b1;
                        r_done_id <= r_job_id;
                        r_state   <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    r_busy      <= 1'b0;
                    r_job_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    aes_periph_txn #(
        .ID_WIDTH  (ID_WIDTH),
        .MASTER_ID (MASTER_ID)
    ) u_txn (
        .clk              (clk_i),
        .rst              (rst_i),
        .i_start          (w_start),
        .i_addr           (w_addr),
        .i_wen            (w_wen),
        .i_data           (w_data),
        .o_gnt_done       (w_gnt_done),
        .o_rsp_valid      (w_rsp_valid),
        .o_rsp_data       (w_rsp_data),
        .o_periph_req     (periph_req_o),
        .i_periph_gnt     (periph_gnt_i),
        .o_periph_add     (periph_add_o),
        .o_periph_wen     (periph_wen_o),
        .o_periph_be      (periph_be_o),
        .o_periph_data    (periph_data_o),
        .o_periph_id      (periph_id_o),
        .i_periph_r_data  (periph_r_data_i),
        .i_periph_r_valid (periph_r_valid_i),
        .i_periph_r_id    (periph_r_id_i)
    );

endmodule
`default_nettype wire
